// File: rtl/branch_flush_ctrl.sv
// Branch redirect/flush sequencer with an in-order prediction tracking queue.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_flush_ctrl #(
  parameter int DEPTH          = 2,
  parameter int RECOVER_CYCLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ID_Branch_i,
  input  logic                     ID_predTaken_i,
  input  logic                     ID_Stall_i,
  input  logic                     EX_Branch_i,
  input  logic                     EX_realTaken_i,
  output logic                     EX_predTaken_o,
  output logic                     Flush_IF_ID_o,
  output logic                     Flush_ID_EX_o,
  output logic [1:0]               pc_select_o,
  output logic                     Stall_ID_o,
  output logic                     Queue_Err_o,
  output logic [CNT_W-1:0]         Branch_Cnt_o,
  output logic [CNT_W-1:0]         Mispred_Cnt_o,
  output logic                     dbg_state_o,
  output logic [$clog2(DEPTH):0]   dbg_q_count_o
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: a push is accepted only in a cycle where w_push is high; a pop
  // happens whenever EX resolves a branch and an entry exists. No back-pressure
  // other than Stall_ID_o, which is raised only when a push would overflow.

  typedef enum logic {S_RUN = 1'b0, S_RECOVER = 1'b1} state_t;

  state_t        r_state;
  logic [1:0]    r_sup_cnt;
  logic          r_q [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_queue_err;

  logic w_empty, w_full, w_head, w_mispredict, w_suppress;
  logic w_stall, w_push, w_pop, w_redirect;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_head       = w_empty ? 1'b0 : r_q[r_rd_ptr];
  assign w_mispredict = EX_Branch_i & (EX_realTaken_i != w_head);
  assign w_suppress   = (r_state == S_RECOVER);
  assign w_stall      = ID_Branch_i & w_full & ~EX_Branch_i;
  assign w_push       = ID_Branch_i & ~ID_Stall_i & ~w_stall & ~w_mispredict & ~w_suppress;
  assign w_pop        = EX_Branch_i & ~w_empty;
  assign w_redirect   = ID_Branch_i & ID_predTaken_i & ~ID_Stall_i & ~w_suppress & ~w_stall;

  always_comb begin
    Flush_IF_ID_o = 1'b0;
    Flush_ID_EX_o = 1'b0;
    pc_select_o   = 2'b00;
    if (w_mispredict) begin
      Flush_IF_ID_o = 1'b1;
      Flush_ID_EX_o = 1'b1;
      pc_select_o   = EX_realTaken_i ? 2'b11 : 2'b10;
    end else if (w_redirect) begin
      Flush_IF_ID_o = 1'b1;
      pc_select_o   = 2'b01;
    end
  end

  assign EX_predTaken_o = w_head;
  assign Stall_ID_o     = w_stall;
  assign Queue_Err_o    = r_queue_err;
  assign dbg_state_o    = (r_state == S_RECOVER);
  assign dbg_q_count_o  = r_count;

  // A mispredict squashes every tracked entry, including a same-cycle push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= 1'b0;
    end else if (w_mispredict) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wr_ptr] <= ID_predTaken_i;
        r_wr_ptr      <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_RUN;
      r_sup_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mispredict) begin
            r_state   <= S_RECOVER;
            r_sup_cnt <= 2'(RECOVER_CYCLES);
          end
        end
        S_RECOVER: begin
          if (w_mispredict) begin
            r_sup_cnt <= 2'(RECOVER_CYCLES);
          end else if (r_sup_cnt == 2'd1) begin
            r_state   <= S_RUN;
            r_sup_cnt <= 2'd0;
          end else begin
            r_sup_cnt <= r_sup_cnt - 2'd1;
          end
        end
        default: begin
          r_state   <= S_RUN;
          r_sup_cnt <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                      r_queue_err <= 1'b0;
    else if (EX_Branch_i & w_empty) r_queue_err <= 1'b1;
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (EX_Branch_i && (r_branch_cnt != '1))   r_branch_cnt  <= r_branch_cnt + 1'b1;
      if (w_mispredict && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign Branch_Cnt_o  = r_branch_cnt;
  assign Mispred_Cnt_o = r_mispred_cnt;
`else
  assign Branch_Cnt_o  = '0;
  assign Mispred_Cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Bench for branch_flush_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_branch_flush_ctrl;
  localparam int DEPTH = 2;
  localparam int RC    = 2;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i, ID_Branch_i, ID_predTaken_i, ID_Stall_i, EX_Branch_i, EX_realTaken_i;
  logic EX_predTaken_o, Flush_IF_ID_o, Flush_ID_EX_o, Stall_ID_o, Queue_Err_o, dbg_state_o;
  logic [1:0] pc_select_o;
  logic [CNT_W-1:0] Branch_Cnt_o, Mispred_Cnt_o;
  logic [1:0] dbg_q_count_o;

  branch_flush_ctrl #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_Branch_i(ID_Branch_i), .ID_predTaken_i(ID_predTaken_i), .ID_Stall_i(ID_Stall_i),
    .EX_Branch_i(EX_Branch_i), .EX_realTaken_i(EX_realTaken_i),
    .EX_predTaken_o(EX_predTaken_o), .Flush_IF_ID_o(Flush_IF_ID_o), .Flush_ID_EX_o(Flush_ID_EX_o),
    .pc_select_o(pc_select_o), .Stall_ID_o(Stall_ID_o), .Queue_Err_o(Queue_Err_o),
    .Branch_Cnt_o(Branch_Cnt_o), .Mispred_Cnt_o(Mispred_Cnt_o),
    .dbg_state_o(dbg_state_o), .dbg_q_count_o(dbg_q_count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: predictions in flight, cycles of suppression left, sticky error, counters
  bit m_q[$];
  int m_sup, m_bc, m_mc;
  bit m_err;

  bit e_pred, e_mis, e_stall, e_fif, e_fid;
  logic [1:0] e_pc;
  logic [17:0] e_vec;
  logic [CNT_W-1:0] e_bc, e_mc;

  task automatic drive(input bit idb, input bit idp, input bit ids,
                       input bit exb, input bit exr, input bit rst);
    bit redir;
    @(negedge clk_i);
    rst_i = rst; ID_Branch_i = idb; ID_predTaken_i = idp; ID_Stall_i = ids;
    EX_Branch_i = exb; EX_realTaken_i = exr;
    e_pred  = (m_q.size() > 0) ? m_q[0] : 1'b0;
    e_mis   = exb && (exr != e_pred);
    e_stall = idb && (m_q.size() == DEPTH) && !exb;
    redir   = !e_mis && idb && idp && !ids && (m_sup == 0) && !e_stall;
    e_pc    = e_mis ? (exr ? 2'd3 : 2'd2) : (redir ? 2'd1 : 2'd0);
    e_fif   = e_mis || redir;
    e_fid   = e_mis;
    e_bc    = STATS ? CNT_W'(m_bc) : '0;
    e_mc    = STATS ? CNT_W'(m_mc) : '0;
    e_vec   = {e_pred, e_fif, e_fid, e_pc, e_stall, m_err, e_bc, e_mc,
               (m_sup > 0), 2'(m_q.size())};
    #1;
  endtask

  task automatic tick();
    bit push;
    push = ID_Branch_i && !ID_Stall_i && !e_stall && !e_mis && (m_sup == 0);
    if (rst_i) begin
      m_q.delete(); m_sup = 0; m_err = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (EX_Branch_i && m_q.size() == 0) m_err = 1;
      if (EX_Branch_i && m_bc < MAXC) m_bc++;
      if (e_mis && m_mc < MAXC) m_mc++;
      if (e_mis) begin
        m_q.delete();
        m_sup = RC;
      end else begin
        if (EX_Branch_i && m_q.size() > 0) void'(m_q.pop_front());
        if (push) m_q.push_back(ID_predTaken_i);
        if (m_sup > 0) m_sup--;
      end
    end
    @(posedge clk_i);
  endtask

  function automatic logic [17:0] obs();
    return {EX_predTaken_o, Flush_IF_ID_o, Flush_ID_EX_o, pc_select_o, Stall_ID_o,
            Queue_Err_o, Branch_Cnt_o, Mispred_Cnt_o, dbg_state_o, dbg_q_count_o};
  endfunction

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== 18'h0) $display("FAIL reset_idle: got %05h expected 00000", obs());
    else n_pass++;
    tick();
  endtask

  task automatic test_predicted_taken();
    logic [CNT_W-1:0] exp_bc;
    drive(1, 1, 0, 0, 0, 0);
    n_checks++;
    if ({pc_select_o, Flush_IF_ID_o, Flush_ID_EX_o} !== 4'b0110)
      $display("FAIL id_redirect: got %b expected 0110", {pc_select_o, Flush_IF_ID_o, Flush_ID_EX_o});
    else n_pass++;
    tick();
    drive(0, 0, 0, 1, 1, 0);
    n_checks++;
    if ({EX_predTaken_o, pc_select_o, Flush_IF_ID_o, Flush_ID_EX_o} !== 5'b10000)
      $display("FAIL ex_correct: got %b expected 10000",
               {EX_predTaken_o, pc_select_o, Flush_IF_ID_o, Flush_ID_EX_o});
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    exp_bc = STATS ? CNT_W'(1) : '0;
    n_checks++;
    if ({Branch_Cnt_o, Mispred_Cnt_o} !== {exp_bc, 4'd0})
      $display("FAIL stats_one: got %0d/%0d expected %0d/0", Branch_Cnt_o, Mispred_Cnt_o, exp_bc);
    else n_pass++;
    tick();
  endtask

  task automatic test_mispredict();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 1, 0);
    n_checks++;
    if ({pc_select_o, Flush_IF_ID_o, Flush_ID_EX_o} !== 4'b1111)
      $display("FAIL mispredict_taken: got %b expected 1111", {pc_select_o, Flush_IF_ID_o, Flush_ID_EX_o});
    else n_pass++;
    tick();
    drive(1, 1, 0, 0, 0, 0);
    n_checks++;
    if ({dbg_state_o, dbg_q_count_o, pc_select_o, Flush_IF_ID_o} !== 6'b100000)
      $display("FAIL recover_suppress: got %b expected 100000",
               {dbg_state_o, dbg_q_count_o, pc_select_o, Flush_IF_ID_o});
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({dbg_state_o, dbg_q_count_o} !== 3'b000)
      $display("FAIL recover_exit: got %b expected 000", {dbg_state_o, dbg_q_count_o});
    else n_pass++;
    tick();
  endtask

  task automatic test_full();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0);
    n_checks++;
    if ({Stall_ID_o, pc_select_o, Flush_IF_ID_o} !== 4'b1000)
      $display("FAIL full_stall: got %b expected 1000", {Stall_ID_o, pc_select_o, Flush_IF_ID_o});
    else n_pass++;
    tick();
    drive(1, 1, 0, 1, 1, 0);
    n_checks++;
    if ({Stall_ID_o, EX_predTaken_o, pc_select_o, Flush_ID_EX_o} !== 5'b01010)
      $display("FAIL full_push_pop: got %b expected 01010",
               {Stall_ID_o, EX_predTaken_o, pc_select_o, Flush_ID_EX_o});
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({dbg_q_count_o, EX_predTaken_o} !== 3'b100)
      $display("FAIL full_count: got %b expected 100", {dbg_q_count_o, EX_predTaken_o});
    else n_pass++;
    tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 1, 0); tick();
  endtask

  task automatic test_empty_err();
    drive(0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({Queue_Err_o, Flush_IF_ID_o, Flush_ID_EX_o, pc_select_o} !== 5'b0)
      $display("FAIL empty_pop: got %b expected 00000",
               {Queue_Err_o, Flush_IF_ID_o, Flush_ID_EX_o, pc_select_o});
    else n_pass++;
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (Queue_Err_o !== 1'b1) $display("FAIL err_sticky: got %b expected 1", Queue_Err_o);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_mc;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 1, 1, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    exp_mc = STATS ? CNT_W'(15) : '0;
    n_checks++;
    if (Mispred_Cnt_o !== exp_mc) $display("FAIL mispred_sat: got %0d expected %0d", Mispred_Cnt_o, exp_mc);
    else n_pass++;
    n_checks++;
    if (Branch_Cnt_o !== exp_mc) $display("FAIL branch_sat: got %0d expected %0d", Branch_Cnt_o, exp_mc);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    drive(1, 1, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== 18'h0) $display("FAIL reset_recover: got %05h expected 00000", obs());
    else n_pass++;
    tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== 18'h0) $display("FAIL reset_queued: got %05h expected 00000", obs());
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    bit exb;
    for (int k = 0; k < 500; k++) begin
      exb = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
            exb, $urandom_range(0, 1), ($urandom_range(0, 99) == 0));
      n_checks++;
      if (obs() !== e_vec) $display("FAIL random_cycle_%0d: got %05h expected %05h", k, obs(), e_vec);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1; ID_Branch_i = 0; ID_predTaken_i = 0; ID_Stall_i = 0;
    EX_Branch_i = 0; EX_realTaken_i = 0;
    m_sup = 0; m_bc = 0; m_mc = 0; m_err = 0;
    test_reset();
    test_predicted_taken();
    test_mispredict();
    test_full();
    test_empty_err();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_flush_ctrl.md
# branch_flush_ctrl

Sequencer that owns PC redirection and pipeline flushing around the 2-bit branch predictor. It records each ID-stage prediction in an in-order tracking queue and replays it when the branch resolves in EX. It arbitrates between EX misprediction recovery and ID predicted-taken redirects, and drives flush and `pc_select` to the IF/ID/EX pipeline registers and the PC mux. It sits between the decoder/hazard unit, the predictor state machine, and the PC source mux.

## Interface
- `DEPTH`, 2: tracking-queue entries; power of two, 2..8.
- `RECOVER_CYCLES`, 1: cycles after a mispredict during which ID redirects are suppressed; 1..3.
- `CNT_W`, 16: width of the statistics counters.

Clock and reset: one clock `clk_i`; reset `rst_i` is synchronous and active-high.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `ID_Branch_i`  in  1  branch instruction decoded in ID.
- `ID_predTaken_i`  in  1  predictor's taken/not-taken for the ID branch.
- `ID_Stall_i`  in  1  hazard-unit stall; ID does not advance.
- `EX_Branch_i`  in  1  branch resolving in EX this cycle.
- `EX_realTaken_i`  in  1  resolved outcome.
- `EX_predTaken_o`  out  1  recorded prediction for the resolving branch (queue head).
- `Flush_IF_ID_o`  out  1  flush the IF/ID register.
- `Flush_ID_EX_o`  out  1  flush the ID/EX register.
- `pc_select_o`  out  2  PC source:
  - 00: PC+4.
  - 01: ID predicted target.
  - 10: EX fall-through.
  - 11: EX branch target.
- `Stall_ID_o`  out  1  queue full; hold ID.
- `Queue_Err_o`  out  1  sticky: EX branch seen with the queue empty.
- `Branch_Cnt_o`  out  CNT_W  resolved branches.
- `Mispred_Cnt_o`  out  CNT_W  mispredictions.

## Operation
- Queue: a DEPTH-entry FIFO of 1-bit predictions with read/write pointers (log2(DEPTH) bits) and a count field (log2(DEPTH)+1 bits).
  - Push: `ID_Branch_i & ~ID_Stall_i & ~Stall_ID_o & ~mispredict & ~suppress`. Pushes `ID_predTaken_i`.
  - Pop: `EX_Branch_i` with the queue non-empty.
  - `EX_predTaken_o` is the head entry, combinational; it is 0 when the queue is empty.
  - Simultaneous push and pop on a full queue is legal; the count is unchanged.
- `mispredict = EX_Branch_i & (EX_realTaken_i != EX_predTaken_o)`.
- Priority, combinational:
  1. `mispredict`: assert both flushes; `pc_select` = 11 if taken, else 10. The whole queue clears next cycle, including any same-cycle push, which is squashed.
  2. Otherwise, `ID_Branch_i & ID_predTaken_i & ~ID_Stall_i & ~suppress & ~Stall_ID_o`: `pc_select` = 01 and `Flush_IF_ID_o` = 1.
  3. Otherwise: `pc_select` = 00 and no flush.
- `Stall_ID_o = ID_Branch_i & full & ~EX_Branch_i`. When asserted, the branch is neither pushed nor redirected.
- FSM states: RUN and RECOVER.
  - RUN → RECOVER on `mispredict`; a down-counter loads RECOVER_CYCLES.
  - RECOVER → RUN when the counter reaches 1 and decrements.
  - A mispredict while in RECOVER reloads the counter.
  - `suppress = (state == RECOVER)`.
- EX branch with the queue empty: treat the prediction as 0, set `Queue_Err_o` (sticky until reset), and apply the normal mispredict rule.
- Counters saturate at all-ones. `Branch_Cnt_o` increments on every `EX_Branch_i`. `Mispred_Cnt_o` increments on every `mispredict`.

## Timing
- Flushes, `pc_select_o`, `Stall_ID_o` and `EX_predTaken_o` are combinational from the inputs and current state, with zero latency.
- Queue, FSM, error and counter updates take effect on the next `posedge clk_i`.
- Reset values:
  - Queue empty; FSM in RUN; suppress counter 0.
  - `Queue_Err_o` = 0; both counters 0.
  - While the queue is empty and inputs are idle, all outputs read 0 and `pc_select_o` = 00.
- Reset mid-recovery or with a non-empty queue discards all state in one cycle. Reset takes priority over simultaneous push, pop and mispredict.
- A push and a mispredict in the same cycle: the mispredict wins and the pushed entry is dropped.

## Configuration
- `BRANCH_STATS_EN`:
  - Defined: both counters and their increment logic are built.
  - Undefined: no counter flops; `Branch_Cnt_o` and `Mispred_Cnt_o` are tied to 0.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then ID branch with pred = 1 and no stall → `pc_select` = 01 and `Flush_IF_ID_o` = 1. Next cycle, EX branch with real = 1 → `EX_predTaken_o` = 1 and no flush; `Branch_Cnt` = 1, `Mispred_Cnt` = 0.
- Push pred = 0, then EX real = 1 → both flushes and `pc_select` = 11. Next cycle: queue empty and state RECOVER. An ID branch with pred = 1 during the RECOVER cycle → `pc_select` = 00 and no push.
- DEPTH = 2: push 1 and 0 with no EX; a third ID branch → `Stall_ID_o` = 1. Same cycle with `EX_Branch_i` = 1 and real = 1 → no stall, pop and push occur, and the count stays 2.
- EX branch with real = 0 and the queue empty → `Queue_Err_o` = 1 next cycle and stays 1; no flush because pred = 0 matches.
- `Mispred_Cnt` preloaded near saturation with CNT_W = 4: 20 mispredicts → holds at 15.
- Assert `rst_i` during RECOVER with 1 entry queued → next cycle state RUN, queue empty, all outputs 0.
